// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light controller and its monitor.
//   state_t        : lamp phase, 2-bit (STOP=0, WAIT=1, GO=2, CAUTION=3)
//   mon_state_t    : monitor FSM state (TRACK, RESYNC)
//   PAT_*          : legal {red,yellow,green} lamp patterns
//   next_phase     : the only legal successor of a phase
//   expected_dwell : enabled cycles a phase should last, from the timer loads
package traffic_light_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        WAIT    = 2'd1,
        GO      = 2'd2,
        CAUTION = 2'd3
    } state_t;

    typedef enum logic {
        TRACK  = 1'b0,
        RESYNC = 1'b1
    } mon_state_t;

    localparam logic [2:0] PAT_STOP    = 3'b100;
    localparam logic [2:0] PAT_WAIT    = 3'b110;
    localparam logic [2:0] PAT_GO      = 3'b001;
    localparam logic [2:0] PAT_CAUTION = 3'b010;

    function automatic state_t next_phase(input state_t p);
        case (p)
            STOP:    return WAIT;
            WAIT:    return GO;
            GO:      return CAUTION;
            default: return STOP;
        endcase
    endfunction

    // The controller reloads its timer with CYCLE_x and advances when it hits
    // zero, so each phase is visible for CYCLE_x+1 enabled cycles.
    function automatic int unsigned expected_dwell(
        input state_t      p,
        input int unsigned c_red,
        input int unsigned c_red_yellow,
        input int unsigned c_green,
        input int unsigned c_yellow
    );
        case (p)
            STOP:    return c_red + 1;
            WAIT:    return c_red_yellow + 1;
            GO:      return c_green + 1;
            default: return c_yellow + 1;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_lamp_decode.sv
// Combinational lamp decoder.
//   pat   : {red,yellow,green}
//   phase : decoded phase (STOP when the pattern is illegal)
//   legal : pattern is one of the four legal patterns
import traffic_light_pkg::*;

module traffic_light_lamp_decode (
    input  logic [2:0] pat,
    output state_t     phase,
    output logic       legal
);

    always_comb begin
        phase = STOP;
        legal = 1'b1;
        case (pat)
            PAT_STOP:    phase = STOP;
            PAT_WAIT:    phase = WAIT;
            PAT_GO:      phase = GO;
            PAT_CAUTION: phase = CAUTION;
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the traffic-light lamp outputs.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : enable shared with the controller
//   red, yellow, green  : observed lamps
//   clear               : synchronous clear of err_sticky/err_count/cycle_count
//   phase, phase_valid  : decoded phase (last legal value held) and legality
//   err_pattern         : pulse, entry into an illegal lamp pattern
//   err_sequence        : pulse, illegal phase order
//   err_timing          : pulse, dwell under/overrun
//   err_sticky          : any error since reset/clear
//   err_count           : saturating count of cycles with an error pulse
//   cycle_done          : pulse on a checked CAUTION->STOP
//   cycle_count         : saturating count of completed light cycles
// Lamps change at edge k, are sampled at k+1, flags appear at k+2.
import traffic_light_pkg::*;

module traffic_light_monitor #(
    parameter int unsigned CYCLE_RED        = 5,
    parameter int unsigned CYCLE_RED_YELLOW = 2,
    parameter int unsigned CYCLE_GREEN      = 5,
    parameter int unsigned CYCLE_YELLOW     = 2,
    parameter int unsigned CNT_WIDTH        = 8,
    parameter int unsigned STAT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  red,
    input  logic                  yellow,
    input  logic                  green,
    input  logic                  clear,
    output logic [1:0]            phase,
    output logic                  phase_valid,
    output logic                  err_pattern,
    output logic                  err_sequence,
    output logic                  err_timing,
    output logic                  err_sticky,
    output logic [STAT_WIDTH-1:0] err_count,
    output logic                  cycle_done,
    output logic [STAT_WIDTH-1:0] cycle_count
);

    // Input stage. Reset to STOP so the first sampled cycle is not an error.
    logic       en_q_reg;
    logic [2:0] pat_q_reg;

    state_t     cur_phase;
    logic       cur_legal;

    // Tracking state
    mon_state_t           state_reg, state_next;
    state_t               phase_reg;      // last legal phase seen
    logic                 phase_valid_reg;
    logic                 prev_legal_reg; // previous sample was legal
    logic [CNT_WIDTH-1:0] dwell_reg, dwell_next;
    logic                 overrun_seen_reg, overrun_seen_next;

    // Output flags
    logic err_pattern_reg, err_pattern_next;
    logic err_sequence_reg, err_sequence_next;
    logic err_timing_reg, err_timing_next;
    logic cycle_done_reg, cycle_done_next;
    logic err_sticky_reg;
    logic [STAT_WIDTH-1:0] err_count_reg, cycle_count_reg;

    logic                 phase_change;
    logic                 order_ok;
    logic [CNT_WIDTH-1:0] dwell_inc;
    logic [CNT_WIDTH-1:0] exp_dwell;
    logic                 overrun_hit;
    logic                 any_err;

    traffic_light_lamp_decode u_decode (
        .pat   (pat_q_reg),
        .phase (cur_phase),
        .legal (cur_legal)
    );

    // Datapath helpers shared by the next-state and output logic
    assign phase_change = cur_legal && (cur_phase != phase_reg);
    assign order_ok     = (cur_phase == next_phase(phase_reg));
    assign dwell_inc    = (en_q_reg && (dwell_reg != '1)) ? dwell_reg + 1'b1 : dwell_reg;
    assign dwell_next   = phase_change ? (en_q_reg ? CNT_WIDTH'(1) : '0) : dwell_inc;
    assign exp_dwell    = CNT_WIDTH'(expected_dwell(phase_reg, CYCLE_RED, CYCLE_RED_YELLOW,
                                                    CYCLE_GREEN, CYCLE_YELLOW));
    // Overrun fires on the enabled cycle that pushes the dwell one past expected.
    assign overrun_hit  = cur_legal && !phase_change && !overrun_seen_reg &&
                          (dwell_inc == exp_dwell + 1'b1);
    assign any_err      = err_pattern_next | err_sequence_next | err_timing_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= TRACK;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TRACK: begin
                if (!cur_legal) begin
                    state_next = RESYNC;
                end else if (phase_change && !order_ok) begin
                    state_next = RESYNC;
                end
            end
            default: begin
                // Only a legal-order step taken directly from a legal sample
                // proves the lamps are back in step.
                if (phase_change && order_ok && prev_legal_reg) begin
                    state_next = TRACK;
                end
            end
        endcase
    end

    // Output logic (next values of the registered flags)
    always_comb begin
        err_pattern_next  = !cur_legal && prev_legal_reg;
        err_sequence_next = 1'b0;
        err_timing_next   = 1'b0;
        cycle_done_next   = 1'b0;
        if ((state_reg == TRACK) && cur_legal) begin
            if (phase_change) begin
                if (!order_ok) begin
                    err_sequence_next = 1'b1;
                end else begin
                    if ((dwell_reg != exp_dwell) && !overrun_seen_reg) begin
                        err_timing_next = 1'b1;
                    end
                    if (phase_reg == CAUTION) begin
                        cycle_done_next = 1'b1;
                    end
                end
            end else if (overrun_hit) begin
                err_timing_next = 1'b1;
            end
        end
        // Without a phase change err_timing can only come from an overrun.
        overrun_seen_next = phase_change ? 1'b0 : (overrun_seen_reg | err_timing_next);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q_reg         <= 1'b0;
            pat_q_reg        <= PAT_STOP;
            phase_reg        <= STOP;
            phase_valid_reg  <= 1'b0;
            prev_legal_reg   <= 1'b1;
            dwell_reg        <= '0;
            overrun_seen_reg <= 1'b0;
            err_pattern_reg  <= 1'b0;
            err_sequence_reg <= 1'b0;
            err_timing_reg   <= 1'b0;
            cycle_done_reg   <= 1'b0;
            err_sticky_reg   <= 1'b0;
            err_count_reg    <= '0;
            cycle_count_reg  <= '0;
        end else begin
            en_q_reg         <= en;
            pat_q_reg        <= {red, yellow, green};
            if (cur_legal) begin
                phase_reg <= cur_phase;
            end
            phase_valid_reg  <= cur_legal;
            prev_legal_reg   <= cur_legal;
            dwell_reg        <= dwell_next;
            overrun_seen_reg <= overrun_seen_next;
            err_pattern_reg  <= err_pattern_next;
            err_sequence_reg <= err_sequence_next;
            err_timing_reg   <= err_timing_next;
            cycle_done_reg   <= cycle_done_next;
            if (clear) begin
                err_sticky_reg  <= 1'b0;
                err_count_reg   <= '0;
                cycle_count_reg <= '0;
            end else begin
                err_sticky_reg <= err_sticky_reg | any_err;
                if (any_err && (err_count_reg != '1)) begin
                    err_count_reg <= err_count_reg + 1'b1;
                end
                if (cycle_done_next && (cycle_count_reg != '1)) begin
                    cycle_count_reg <= cycle_count_reg + 1'b1;
                end
            end
        end
    end

    assign phase        = phase_reg;
    assign phase_valid  = phase_valid_reg;
    assign err_pattern  = err_pattern_reg;
    assign err_sequence = err_sequence_reg;
    assign err_timing   = err_timing_reg;
    assign err_sticky   = err_sticky_reg;
    assign err_count    = err_count_reg;
    assign cycle_done   = cycle_done_reg;
    assign cycle_count  = cycle_count_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor. Each driven sample pushes its
// expected outputs; they are compared when the DUT produces them two edges on.
module tb_traffic_light_monitor;

    localparam logic [2:0] P_STOP = 3'b100;
    localparam logic [2:0] P_WAIT = 3'b110;
    localparam logic [2:0] P_GO   = 3'b001;
    localparam logic [2:0] P_CAUT = 3'b010;
    localparam logic [2:0] P_BAD  = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        red = 1'b1, yellow = 1'b0, green = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  phase;
    logic        phase_valid, err_pattern, err_sequence, err_timing, err_sticky, cycle_done;
    logic [15:0] err_count, cycle_count;

    typedef struct packed {
        logic [1:0] ph;
        logic       v;
        logic       ep;
        logic       es;
        logic       et;
        logic       cd;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    string cur_test = "none";

    traffic_light_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .red          (red),
        .yellow       (yellow),
        .green        (green),
        .clear        (clear),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .err_pattern  (err_pattern),
        .err_sequence (err_sequence),
        .err_timing   (err_timing),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .cycle_done   (cycle_done),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    // Drive one sample, push its expectation, advance one edge and score the
    // sample whose outputs are now visible.
    task automatic drive_sample(input logic [2:0] pat, input logic e, input logic clr, input exp_t x);
        exp_t got;
        exp_t want;
        {red, yellow, green} = pat;
        en    = e;
        clear = clr;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            want = exp_q.pop_front();
            got  = {phase, phase_valid, err_pattern, err_sequence, err_timing, cycle_done};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s sample: got ph=%0d v=%b ep=%b es=%b et=%b cd=%b, required ph=%0d v=%b ep=%b es=%b et=%b cd=%b",
                         cur_test, got.ph, got.v, got.ep, got.es, got.et, got.cd,
                         want.ph, want.v, want.ep, want.es, want.et, want.cd);
            end else begin
                $display("ok   %s sample: ph=%0d v=%b flags=%b%b%b%b", cur_test,
                         got.ph, got.v, got.ep, got.es, got.et, got.cd);
            end
        end
    endtask

    // A lamp segment: n_en enabled samples of pat (random disabled samples
    // interleaved when rand_en), then n_idle disabled samples. The first
    // sample carries the transition flags; ov_k marks the enabled sample that
    // must raise an overrun.
    task automatic seg(input logic [2:0] pat, input int n_en, input bit rand_en, input int n_idle,
                       input logic [1:0] xph, input logic xv,
                       input logic f_ep, input logic f_es, input logic f_et, input logic f_cd,
                       input int ov_k);
        int   cnt = 0;
        int   s = 0;
        logic e_now;
        exp_t x;
        while (cnt < n_en) begin
            e_now = rand_en ? logic'($urandom_range(0, 1)) : 1'b1;
            if (s > 200) e_now = 1'b1;
            if (e_now) cnt++;
            x = '{ph: xph, v: xv, ep: 1'b0, es: 1'b0, et: 1'b0, cd: 1'b0};
            if (s == 0) begin
                x.ep = f_ep; x.es = f_es; x.et = f_et; x.cd = f_cd;
            end
            if (e_now && (ov_k != 0) && (cnt == ov_k)) x.et = 1'b1;
            drive_sample(pat, e_now, 1'b0, x);
            s++;
        end
        for (int i = 0; i < n_idle; i++) begin
            x = '{ph: xph, v: 1'b1, ep: 1'b0, es: 1'b0, et: 1'b0, cd: 1'b0};
            drive_sample(pat, 1'b0, 1'b0, x);
        end
    endtask

    // One full light cycle starting from WAIT, ending with a checked STOP.
    task automatic light_cycle(input bit rand_en);
        seg(P_WAIT, 3, rand_en, 0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        seg(P_GO,   6, rand_en, 0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        seg(P_CAUT, 3, rand_en, 0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        seg(P_STOP, 6, rand_en, 2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic check_stats(input string tag, input logic [15:0] x_err, input logic [15:0] x_cyc,
                               input logic x_sticky);
        n_checks++;
        if ((err_count !== x_err) || (cycle_count !== x_cyc) || (err_sticky !== x_sticky)) begin
            n_fail++;
            $display("FAIL %s stats: got err_count=%0d cycle_count=%0d sticky=%b, required %0d %0d %b",
                     tag, err_count, cycle_count, err_sticky, x_err, x_cyc, x_sticky);
        end else begin
            $display("ok   %s stats: err_count=%0d cycle_count=%0d sticky=%b", tag, err_count, cycle_count, err_sticky);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst_n = 1'b0;
        {red, yellow, green} = P_STOP;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({phase, phase_valid, err_pattern, err_sequence, err_timing, cycle_done} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got ph=%0d v=%b ep=%b es=%b et=%b cd=%b, required all 0",
                     phase, phase_valid, err_pattern, err_sequence, err_timing, cycle_done);
        end else begin
            $display("ok   reset outputs zero");
        end
        check_stats("reset", 16'd0, 16'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_golden();
        cur_test = "golden";
        seg(P_STOP, 6, 1'b0, 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        light_cycle(1'b0);
        light_cycle(1'b0);
        check_stats("golden", 16'd0, 16'd2, 1'b0);
    endtask

    task automatic test_random_en();
        cur_test = "random_en";
        light_cycle(1'b1);
        check_stats("random_en", 16'd0, 16'd3, 1'b0);
    endtask

    task automatic test_short_go();
        cur_test = "short_go";
        seg(P_WAIT, 3, 1'b0, 0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        seg(P_GO,   5, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        seg(P_CAUT, 3, 1'b0, 0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        seg(P_STOP, 6, 1'b0, 2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check_stats("short_go", 16'd1, 16'd4, 1'b1);
    endtask

    task automatic test_long_go();
        cur_test = "long_go";
        seg(P_WAIT, 3, 1'b0, 0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        seg(P_GO,   8, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7);
        seg(P_CAUT, 3, 1'b0, 0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        seg(P_STOP, 6, 1'b0, 2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check_stats("long_go", 16'd2, 16'd5, 1'b1);
    endtask

    task automatic test_pattern_glitch();
        cur_test = "glitch";
        seg(P_BAD,  1, 1'b0, 0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        seg(P_STOP, 2, 1'b0, 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        light_cycle(1'b0);
        check_stats("glitch", 16'd3, 16'd6, 1'b1);
    endtask

    task automatic test_sequence();
        cur_test = "sequence";
        seg(P_GO,   6, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        seg(P_CAUT, 3, 1'b0, 0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        seg(P_STOP, 6, 1'b0, 2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check_stats("sequence", 16'd4, 16'd7, 1'b1);
    endtask

    task automatic test_clear();
        exp_t x;
        cur_test = "clear";
        x = '{ph: 2'd0, v: 1'b1, ep: 1'b0, es: 1'b0, et: 1'b0, cd: 1'b0};
        drive_sample(P_STOP, 1'b0, 1'b1, x);
        seg(P_STOP, 0, 1'b0, 2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_stats("clear", 16'd0, 16'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        cur_test = "reset_mid";
        seg(P_WAIT, 3, 1'b0, 0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        seg(P_GO,   3, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({phase, phase_valid, err_pattern, err_sequence, err_timing, cycle_done} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got ph=%0d v=%b ep=%b es=%b et=%b cd=%b, required all 0",
                     phase, phase_valid, err_pattern, err_sequence, err_timing, cycle_done);
        end else begin
            $display("ok   reset_mid outputs zero");
        end
        exp_q.delete();
        {red, yellow, green} = P_STOP;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seg(P_STOP, 6, 1'b0, 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        light_cycle(1'b0);
        check_stats("reset_mid", 16'd0, 16'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_random_en();
        test_short_go();
        test_long_go();
        test_pattern_glitch();
        test_sequence();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
